// File: rtl/prim_rom_arbiter.sv
// prim_rom_arbiter
//   Shares one ROM read port between NumReq requesters. A round-robin
//   arbiter issues at most one read per cycle, an ID FIFO remembers the
//   owner of every in-flight read, and the returned word is steered back
//   to that owner through a registered return path.
//
// Ports
//   clk_i         clock
//   rst_i         asynchronous reset, active-high
//   req_i         per-requester read request (held until granted)
//   addr_i        per-requester word address, slice i = [i*Aw +: Aw]
//   gnt_o         one-hot (or zero) grant, combinational
//   rvalid_o      one-hot (or zero) read-data valid, registered
//   rdata_o       read data shared by all requesters, registered
//   rom_cs_o      ROM chip select
//   rom_addr_o    ROM word address
//   rom_dout_i    ROM read data
//   rom_dvalid_i  ROM read data valid
//   err_o         sticky flag: ROM data arrived with no read outstanding
module prim_rom_arbiter #(
   parameter int NumReq = 2,
   parameter int Width  = 32,
   parameter int Depth  = 2048,
   parameter int Aw     = $clog2(Depth),
   parameter int MaxOut = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NumReq-1:0]    req_i,
   input  logic [NumReq*Aw-1:0] addr_i,
   output logic [NumReq-1:0]    gnt_o,
   output logic [NumReq-1:0]    rvalid_o,
   output logic [Width-1:0]     rdata_o,
   output logic                 rom_cs_o,
   output logic [Aw-1:0]        rom_addr_o,
   input  logic [Width-1:0]     rom_dout_i,
   input  logic                 rom_dvalid_i,
   output logic                 err_o
);

   localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int PtrW = (MaxOut > 1) ? $clog2(MaxOut) : 1;
   localparam int CntW = $clog2(MaxOut + 1);

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOut - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [IdW-1:0]    rr_q, rr_d;
   logic [IdW-1:0]    id_mem_q [MaxOut];
   logic [PtrW-1:0]   wr_q, rd_q;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [NumReq-1:0] rvalid_q, rvalid_d;
   logic [Width-1:0]  rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              can_issue, gnt_vld, push, pop, spurious;
   logic [IdW-1:0]    win, head;
   logic [NumReq-1:0] gnt;
   logic [Aw-1:0]     sel_addr;

   // Round-robin scan: first pass covers indices at or above the pointer,
   // second pass wraps around to the indices below it. A pop in this cycle
   // does not free a slot, so issue depends only on the registered count.
   // Reset also blocks issue so nothing reaches the ROM while held.
   always_comb begin
      can_issue = !rst_i && (cnt_q < CntW'(MaxOut));
      gnt_vld   = 1'b0;
      win       = '0;
      gnt       = '0;
      sel_addr  = '0;
      rr_d      = rr_q;
      for (int i = 0; i < NumReq; i++) begin
         if (can_issue && !gnt_vld && req_i[i] && (i >= int'(rr_q))) begin
            gnt_vld  = 1'b1;
            win      = IdW'(i);
            gnt[i]   = 1'b1;
            sel_addr = addr_i[i*Aw +: Aw];
            rr_d     = (i == NumReq - 1) ? '0 : IdW'(i + 1);
         end
      end
      for (int i = 0; i < NumReq; i++) begin
         if (can_issue && !gnt_vld && req_i[i] && (i < int'(rr_q))) begin
            gnt_vld  = 1'b1;
            win      = IdW'(i);
            gnt[i]   = 1'b1;
            sel_addr = addr_i[i*Aw +: Aw];
            rr_d     = (i == NumReq - 1) ? '0 : IdW'(i + 1);
         end
      end
   end

   // ID FIFO bookkeeping and return path. A dvalid with nothing
   // outstanding is an error: it neither pops nor produces an rvalid.
   always_comb begin
      push     = gnt_vld;
      pop      = rom_dvalid_i && (cnt_q != '0);
      spurious = rom_dvalid_i && (cnt_q == '0);
      head     = id_mem_q[rd_q];
      cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
      err_d    = err_q | spurious;
      rvalid_d = '0;
      rdata_d  = rdata_q;
      if (pop) begin
         for (int i = 0; i < NumReq; i++) begin
            rvalid_d[i] = (head == IdW'(i));
         end
         rdata_d = rom_dout_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q     <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         if (push) wr_q <= next_ptr(wr_q);
         if (pop)  rd_q <= next_ptr(rd_q);
      end
   end

   // ID storage holds no state that matters after reset (pointers and count
   // are cleared), so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (push) id_mem_q[wr_q] <= win;
   end

   assign gnt_o      = gnt;
   assign rom_cs_o   = gnt_vld;
   assign rom_addr_o = gnt_vld ? sel_addr : '0;
   assign rvalid_o   = rvalid_q;
   assign rdata_o    = rdata_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_prim_rom_arbiter.sv
module tb_prim_rom_arbiter;
   localparam int NumReq = 2;
   localparam int Width  = 32;
   localparam int Depth  = 2048;
   localparam int Aw     = 11;
   localparam int MaxOut = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NumReq-1:0]    req;
   logic [Aw-1:0]        a0, a1;
   logic [NumReq-1:0]    gnt_o, rvalid_o;
   logic [Width-1:0]     rdata_o;
   logic                 rom_cs_o;
   logic [Aw-1:0]        rom_addr_o;
   logic [Width-1:0]     rom_dout;
   logic                 rom_dvalid;
   logic                 err_o;

   prim_rom_arbiter #(
      .NumReq(NumReq), .Width(Width), .Depth(Depth), .Aw(Aw), .MaxOut(MaxOut)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i({a1, a0}),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .rom_cs_o(rom_cs_o), .rom_addr_o(rom_addr_o),
      .rom_dout_i(rom_dout), .rom_dvalid_i(rom_dvalid), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // ---------------- ROM model ----------------
   typedef struct {logic [Aw-1:0] a; int due;} pend_t;
   pend_t pend[$];
   int    cyc = 0;
   int    lat = 1;
   logic  spur = 1'b0;

   function automatic logic [Width-1:0] rom_word(input logic [Aw-1:0] a);
      return (a == 11'h010) ? 32'hDEADBEEF : (32'hA5000000 | {21'd0, a});
   endfunction

   always @(negedge clk) begin
      if (rom_cs_o) pend.push_back('{a: rom_addr_o, due: cyc + lat});
   end

   always @(posedge clk) begin
      cyc++;
      #2;
      rom_dvalid = 1'b0;
      rom_dout   = 32'h0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         rom_dvalid = 1'b1;
         rom_dout   = rom_word(pend[0].a);
         void'(pend.pop_front());
      end else if (spur) begin
         rom_dvalid = 1'b1;
         rom_dout   = 32'h0BAD0BAD;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {int id; logic [Width-1:0] d;} exp_t;
   exp_t sb[$];

   task automatic expect_rd(input int id, input logic [Width-1:0] d);
      sb.push_back('{id: id, d: d});
   endtask

   always @(negedge clk) begin
      if (!rst && rvalid_o != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_rvalid", {62'd0, rvalid_o}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rvalid_owner", {62'd0, rvalid_o}, 64'd1 << e.id);
            chk("rdata", {32'd0, rdata_o}, {32'd0, e.d});
         end
      end
   end

   // One cycle: drive vector at +1, check grant at +3, advance to next +1.
   task automatic step(input logic [1:0] rq, input logic [Aw-1:0] x0,
                       input logic [Aw-1:0] x1, input logic [1:0] eg, input string nm);
      req = rq; a0 = x0; a1 = x1;
      #2;
      chk({nm, "_gnt"}, {62'd0, gnt_o}, {62'd0, eg});
      chk({nm, "_cs"}, {63'd0, rom_cs_o}, {63'd0, |eg});
      if (eg != 2'b00)
         chk({nm, "_addr"}, {53'd0, rom_addr_o}, {53'd0, (eg[0] ? x0 : x1)});
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, '0, '0, 2'b00, "idle");
   endtask

   initial begin
      rst = 1'b1; req = '0; a0 = '0; a1 = '0; rom_dvalid = 1'b0; rom_dout = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", {62'd0, gnt_o}, 64'd0);
      chk("rst_rvalid", {62'd0, rvalid_o}, 64'd0);
      chk("rst_rdata", {32'd0, rdata_o}, 64'd0);
      chk("rst_cs", {63'd0, rom_cs_o}, 64'd0);
      chk("rst_err", {63'd0, err_o}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: single request, 2-cycle return latency
      expect_rd(0, 32'hDEADBEEF);
      step(2'b01, 11'h010, 11'h000, 2'b01, "t1");
      step(2'b00, 11'h000, 11'h000, 2'b00, "t1_wait");
      chk("t1_rvalid_lat", {62'd0, rvalid_o}, 64'd1);
      chk("t1_rdata_lat", {32'd0, rdata_o}, 64'hDEADBEEF);
      // move pointer back to 0 with a grant to requester 1
      expect_rd(1, 32'hA5000020);
      step(2'b10, 11'h000, 11'h020, 2'b10, "t1b");
      idle(3);

      // 2: contention, alternating grants
      expect_rd(0, 32'hA5000030); step(2'b11, 11'h030, 11'h040, 2'b01, "t2_c0");
      expect_rd(1, 32'hA5000040); step(2'b11, 11'h030, 11'h040, 2'b10, "t2_c1");
      expect_rd(0, 32'hA5000030); step(2'b11, 11'h030, 11'h040, 2'b01, "t2_c2");
      expect_rd(1, 32'hA5000040); step(2'b11, 11'h030, 11'h040, 2'b10, "t2_c3");
      idle(3);

      // 3/4: slow ROM, slots exhausted, pop in same cycle does not free a slot
      lat = 3;
      expect_rd(0, 32'hA5000050); step(2'b01, 11'h050, 11'h000, 2'b01, "t3_c0");
      expect_rd(0, 32'hA5000051); step(2'b01, 11'h051, 11'h000, 2'b01, "t3_c1");
      step(2'b01, 11'h052, 11'h000, 2'b00, "t3_full");
      step(2'b01, 11'h052, 11'h000, 2'b00, "t4_full_pop");
      expect_rd(0, 32'hA5000052); step(2'b01, 11'h052, 11'h000, 2'b01, "t4_after_pop");
      expect_rd(0, 32'hA5000053); step(2'b01, 11'h053, 11'h000, 2'b01, "t3_c5");
      idle(6);
      lat = 1;

      // 5: spurious dvalid
      spur = 1'b1;
      step(2'b00, 11'h000, 11'h000, 2'b00, "t5_spur");
      spur = 1'b0;
      chk("t5_err_set", {63'd0, err_o}, 64'd1);
      chk("t5_no_rvalid", {62'd0, rvalid_o}, 64'd0);
      idle(3);
      chk("t5_err_sticky", {63'd0, err_o}, 64'd1);

      // 6: reset while a read is in flight
      lat = 3;
      step(2'b01, 11'h070, 11'h000, 2'b01, "t6_gnt");
      rst = 1'b1; req = 2'b11; a0 = 11'h080; a1 = 11'h090;
      #2;
      chk("t6_rst_gnt", {62'd0, gnt_o}, 64'd0);
      chk("t6_rst_cs", {63'd0, rom_cs_o}, 64'd0);
      chk("t6_rst_rvalid", {62'd0, rvalid_o}, 64'd0);
      chk("t6_rst_rdata", {32'd0, rdata_o}, 64'd0);
      chk("t6_rst_err", {63'd0, err_o}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(3);
      chk("t6_late_err", {63'd0, err_o}, 64'd1);
      chk("t6_late_no_rvalid", {62'd0, rvalid_o}, 64'd0);
      lat = 1;
      expect_rd(0, 32'hA5000080);
      step(2'b11, 11'h080, 11'h090, 2'b01, "t6_fresh");
      step(2'b00, 11'h000, 11'h000, 2'b00, "t6_wait");
      chk("t6_fresh_rvalid", {62'd0, rvalid_o}, 64'd1);
      chk("t6_fresh_rdata", {32'd0, rdata_o}, 64'hA5000080);
      idle(3);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
